// File: rtl/dsp_dec_requant.sv
// Decimator output stage: rounding arithmetic right shift, 16-bit saturation,
// and a first-word-fall-through FIFO with a valid/ready consumer port and sticky flags.
module dsp_dec_requant #(
    parameter int unsigned W_IN  = 32,
    parameter int unsigned W_OUT = 16,
    parameter int unsigned SH_W  = 5,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [W_IN-1:0]            din,
    input  logic                       din_val,
    input  logic [SH_W-1:0]            shift,
    input  logic                       flag_clr,
    output logic [W_OUT-1:0]           dout,
    output logic                       dout_val,
    input  logic                       dout_rdy,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       sat_flag,
    output logic                       ovf_flag
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [W_IN:0] ONE = {{W_IN{1'b0}}, 1'b1};

    logic                     v1_q;
    logic [SH_W-1:0]          sh_q;
    logic signed [W_IN:0]     sum_q, sum_d, bias_w;
    logic signed [W_IN:0]     q_w;
    logic                     clip_hi, clip_lo;
    logic [W_OUT-1:0]         res_w;

    logic [W_OUT-1:0]         mem_q [DEPTH];
    logic [AW-1:0]            wr_q, rd_q, rd_d;
    logic [LW-1:0]            lvl_q, lvl_d, rem_w;
    logic [W_OUT-1:0]         dout_q, dout_d;
    logic                     sat_q, sat_d, ovf_q, ovf_d;
    logic                     pop, push, full;

    // Bias of 2^(s-1), one less for negative inputs, makes the floor shift
    // round half away from zero.
    always_comb begin
        bias_w = '0;
        if (shift != '0) begin
            bias_w = ONE << (shift - SH_W'(1));
            if (din[W_IN-1]) begin
                bias_w = bias_w - ONE;
            end
        end
        sum_d = $signed({din[W_IN-1], din}) + bias_w;
    end

    always_comb begin
        q_w     = sum_q >>> sh_q;
        clip_hi = !q_w[W_IN] && (q_w[W_IN-1:W_OUT-1] != '0);
        clip_lo =  q_w[W_IN] && (q_w[W_IN-1:W_OUT-1] != '1);
        res_w   = q_w[W_OUT-1:0];
        if (clip_hi) begin
            res_w = {1'b0, {(W_OUT-1){1'b1}}};
        end else if (clip_lo) begin
            res_w = {1'b1, {(W_OUT-1){1'b0}}};
        end
    end

    always_comb begin
        full  = (lvl_q == LW'(DEPTH));
        pop   = (lvl_q != '0) && dout_rdy;
        push  = v1_q && (!full || pop);
        lvl_d = lvl_q + LW'(push) - LW'(pop);
        rd_d  = rd_q + AW'(pop);
        rem_w = lvl_q - LW'(pop);
        sat_d = (sat_q && !flag_clr) || (v1_q && (clip_hi || clip_lo));
        ovf_d = (ovf_q && !flag_clr) || (v1_q && full && !pop);
        // Head register: next stored entry if one survives the pop, else the
        // incoming sample, else keep the last popped value.
        dout_d = dout_q;
        if (rem_w != '0) begin
            dout_d = mem_q[rd_d];
        end else if (push) begin
            dout_d = res_w;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= res_w;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            sh_q   <= '0;
            sum_q  <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            lvl_q  <= '0;
            dout_q <= '0;
            sat_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            v1_q <= din_val;
            if (din_val) begin
                sh_q  <= shift;
                sum_q <= sum_d;
            end
            if (push) begin
                wr_q <= wr_q + AW'(1);
            end
            rd_q   <= rd_d;
            lvl_q  <= lvl_d;
            dout_q <= dout_d;
            sat_q  <= sat_d;
            ovf_q  <= ovf_d;
        end
    end

    assign dout     = dout_q;
    assign dout_val = (lvl_q != '0);
    assign level    = lvl_q;
    assign sat_flag = sat_q;
    assign ovf_flag = ovf_q;

endmodule

// File: tb/tb_dsp_dec_requant.sv
// Bench for dsp_dec_requant: directed cases plus random traffic against a
// queue-based reference using integer round-half-away-from-zero arithmetic.
module tb_dsp_dec_requant;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] din;
    logic        din_val;
    logic [4:0]  shift;
    logic        flag_clr;
    logic [15:0] dout;
    logic        dout_val;
    logic        dout_rdy;
    logic [3:0]  level;
    logic        sat_flag;
    logic        ovf_flag;

    int unsigned passed = 0;
    int unsigned total  = 0;

    logic [15:0] mq[$];
    logic [15:0] mlast;
    logic [15:0] mr;
    bit          mv1, mc, msat, movf;

    always #5 clk = ~clk;

    dsp_dec_requant #(.W_IN(32), .W_OUT(16), .SH_W(5), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_val(din_val), .shift(shift),
        .flag_clr(flag_clr), .dout(dout), .dout_val(dout_val), .dout_rdy(dout_rdy),
        .level(level), .sat_flag(sat_flag), .ovf_flag(ovf_flag)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void ref_rq(input logic [31:0] d, input logic [4:0] s,
                                   output logic [15:0] r, output bit c);
        longint v, a, q;
        int     sh;
        v  = longint'($signed(d));
        sh = int'(s);
        if (sh == 0) begin
            q = v;
        end else begin
            a = (v < 0) ? -v : v;
            q = (a + (longint'(1) << (sh - 1))) >> sh;
            if (v < 0) q = -q;
        end
        c = (q > 32767) || (q < -32768);
        if (q > 32767)       r = 16'h7FFF;
        else if (q < -32768) r = 16'h8000;
        else                 r = q[15:0];
    endfunction

    task automatic model_reset();
        mq.delete();
        mlast = '0;
        mr    = '0;
        mv1   = 1'b0;
        mc    = 1'b0;
        msat  = 1'b0;
        movf  = 1'b0;
    endtask

    task automatic model_edge();
        bit pop, full;
        pop  = (mq.size() != 0) && dout_rdy;
        full = (mq.size() == DEPTH);
        if (pop) mlast = mq.pop_front();
        movf = (movf && !flag_clr) || (mv1 && full && !pop);
        msat = (msat && !flag_clr) || (mv1 && mc);
        if (mv1 && (!full || pop)) mq.push_back(mr);
        mv1 = din_val;
        if (din_val) ref_rq(din, shift, mr, mc);
    endtask

    task automatic check_outputs(input string pre);
        logic [15:0] head;
        head = (mq.size() != 0) ? mq[0] : mlast;
        chk({pre, ".dout_val"}, 32'(dout_val), 32'(mq.size() != 0));
        chk({pre, ".level"},    32'(level),    32'(mq.size()));
        chk({pre, ".dout"},     32'(dout),     32'(head));
        chk({pre, ".sat_flag"}, 32'(sat_flag), 32'(msat));
        chk({pre, ".ovf_flag"}, 32'(ovf_flag), 32'(movf));
    endtask

    task automatic cyc(input string pre);
        model_edge();
        @(posedge clk);
        #1;
        check_outputs(pre);
    endtask

    task automatic send(input string tag, input logic [31:0] d, input logic [4:0] s,
                        input logic [15:0] exp);
        din = d; shift = s; din_val = 1'b1;
        cyc(tag);
        din_val = 1'b0;
        cyc(tag);
        chk({tag, ".const_dout"}, 32'(dout), 32'(exp));
        chk({tag, ".const_val"},  32'(dout_val), 32'd1);
        cyc(tag);
        cyc(tag);
    endtask

    initial begin
        rst_n = 1'b0; din = '0; din_val = 1'b0; shift = '0; flag_clr = 1'b0; dout_rdy = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        rst_n = 1'b1;

        // Rounding at shift 16
        dout_rdy = 1'b1;
        send("t1a", 32'h0001_8000, 5'd16, 16'h0002);
        send("t1b", 32'hFFFE_8000, 5'd16, 16'hFFFE);
        send("t1c", 32'hFFFE_C000, 5'd16, 16'hFFFF);
        chk("t1.sat_zero", 32'(sat_flag), 32'd0);

        // Saturation and flag clearing
        send("t2a", 32'h0001_0000, 5'd0, 16'h7FFF);
        chk("t2.sat_set", 32'(sat_flag), 32'd1);
        send("t2b", 32'h8000_0000, 5'd0, 16'h8000);
        flag_clr = 1'b1;
        cyc("t2clr");
        flag_clr = 1'b0;
        chk("t2.sat_cleared", 32'(sat_flag), 32'd0);
        din = 32'h0001_0000; shift = 5'd0; din_val = 1'b1;
        cyc("t2co");
        din_val = 1'b0; flag_clr = 1'b1;
        cyc("t2co");
        flag_clr = 1'b0;
        chk("t2.sat_coincident", 32'(sat_flag), 32'd1);
        cyc("t2co");

        // Single-sample latency
        din = 32'd123; shift = 5'd0; din_val = 1'b1;
        cyc("t3");
        din_val = 1'b0;
        chk("t3.val_n", 32'(dout_val), 32'd0);
        chk("t3.lvl_n", 32'(level), 32'd0);
        cyc("t3");
        chk("t3.val_n1", 32'(dout_val), 32'd1);
        chk("t3.lvl_n1", 32'(level), 32'd1);
        cyc("t3");
        chk("t3.lvl_n2", 32'(level), 32'd0);

        // Overflow with consumer stalled
        flag_clr = 1'b1;
        cyc("t4");
        flag_clr = 1'b0;
        dout_rdy = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            din = 32'(i); shift = 5'd0; din_val = 1'b1;
            cyc("t4fill");
        end
        din_val = 1'b0;
        cyc("t4fill");
        chk("t4.level_full", 32'(level), 32'd8);
        chk("t4.ovf_set", 32'(ovf_flag), 32'd1);
        dout_rdy = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("t4.drain_dout", 32'(dout), 32'(i));
            cyc("t4drain");
        end
        chk("t4.level_empty", 32'(level), 32'd0);

        // Push and pop on the same edge while full
        flag_clr = 1'b1; dout_rdy = 1'b0;
        cyc("t5");
        flag_clr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            din = 32'(100 + i); din_val = 1'b1;
            cyc("t5fill");
        end
        din_val = 1'b0;
        cyc("t5fill");
        din = 32'h77; din_val = 1'b1;
        cyc("t5pp");
        din_val = 1'b0; dout_rdy = 1'b1;
        cyc("t5pp");
        chk("t5.level_full", 32'(level), 32'd8);
        chk("t5.ovf_clear", 32'(ovf_flag), 32'd0);
        for (int i = 0; i < 3 * DEPTH; i++) begin
            din = $urandom; shift = 5'($urandom_range(8, 20)); din_val = 1'b1;
            cyc("t5stream");
        end
        din_val = 1'b0;
        repeat (12) cyc("t5tail");

        // Asynchronous reset mid-stream
        dout_rdy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            din = 32'h0001_0000 + 32'(i); shift = 5'd0; din_val = 1'b1;
            cyc("t6fill");
        end
        din_val = 1'b0;
        chk("t6.pre_level", 32'(level), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("t6.rst_val",  32'(dout_val), 32'd0);
        chk("t6.rst_lvl",  32'(level),    32'd0);
        chk("t6.rst_sat",  32'(sat_flag), 32'd0);
        chk("t6.rst_ovf",  32'(ovf_flag), 32'd0);
        chk("t6.rst_dout", 32'(dout),     32'd0);
        #1;
        rst_n = 1'b1;
        din = 32'd5; shift = 5'd0; din_val = 1'b1; dout_rdy = 1'b1;
        cyc("t6post");
        din_val = 1'b0;
        chk("t6.post_val1", 32'(dout_val), 32'd0);
        cyc("t6post");
        chk("t6.post_val2", 32'(dout_val), 32'd1);
        chk("t6.post_dout", 32'(dout), 32'd5);
        cyc("t6post");

        // Random traffic: stalled consumer first, then mostly-ready
        for (int i = 0; i < 500; i++) begin
            din = $urandom;
            if ($urandom_range(0, 1) == 1) din = $unsigned($signed(din) >>> $urandom_range(8, 24));
            shift    = 5'($urandom_range(0, 31));
            din_val  = 1'($urandom_range(0, 1));
            flag_clr = ($urandom_range(0, 15) == 0);
            dout_rdy = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            cyc("rand");
        end
        din_val = 1'b0; flag_clr = 1'b0; dout_rdy = 1'b1;
        repeat (12) cyc("rand_tail");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
